fir_decim_buffer: RTL

//   Output stage directly downstream of FIR_63TAP. Averages each block of 2**LOG2_DECIM

---
 rtl/fir_pkg.sv | 34 +++
 rtl/fir_decim_buffer_if.sv | 26 ++
 rtl/fir_decim_buffer_sync_fifo.sv | 68 ++++++
 rtl/fir_decim_buffer.sv | 104 ++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output chain: sample width, sample type and the
// rounding/saturating shift that every decimating stage applies to its block sums.
package fir_pkg;

    localparam int FIR_DW = 10;

    typedef logic signed [FIR_DW-1:0] sample_t;

    // Round half up (add half an LSB of the result, then arithmetic shift), then clamp
    // the result into the signed range of a dw-bit word.
    function automatic logic signed [31:0] round_shift_sat(
        input logic signed [31:0] sum,
        input int                 shift,
        input int                 dw
    );
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        if (shift > 0) begin
            r = (sum + (32'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            r = sum;
        end
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_decim_buffer_if.sv
// Sample input, decimated output stream and status of the FIR decimating buffer.
// The buffer is the slave; whoever feeds it samples and drains its output is the master.
interface fir_decim_buffer_if #(
    parameter int DW    = 10,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
    logic                         in_valid;
    logic signed [DW-1:0]         in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DW-1:0]         out_data;
    logic [$clog2(DEPTH+1)-1:0]   level;
    logic                         overflow;
    logic [CNT_W-1:0]             drop_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, level, overflow, drop_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, level, overflow, drop_count
    );
endinterface

// File: rtl/fir_decim_buffer_sync_fifo.sv
// Single-clock FIFO with a registered head word. The caller only pushes when there is
// room (or a pop frees a slot on the same edge) and only pops when not empty.
module sync_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wr_data,
    output logic [DW-1:0]              rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          bypass;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        // The only time the new head is the word being written right now is when the
        // FIFO holds nothing else after this edge; the array still has the old content.
        bypass    = push && (level_q == LW'(pop));
        rd_data_d = bypass ? wr_data : mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign level   = level_q;
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);

endmodule

// File: rtl/fir_decim_buffer.sv
// Averages each block of 2**LOG2_DECIM FIR samples into one rounded, clamped word, queues
// the words for a valid/ready sink and counts words lost while the queue is full.
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int DW         = FIR_DW,
    parameter int LOG2_DECIM = 2,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    fir_decim_buffer_if.slave bus
);
    localparam int D      = 1 << LOG2_DECIM;
    localparam int ACC_W  = DW + LOG2_DECIM;
    localparam int PH_W   = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;

    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    overflow_q, overflow_d;
    logic [CNT_W-1:0]        drop_count_q, drop_count_d;

    logic signed [ACC_W-1:0] sum;
    logic signed [31:0]      word_wide;
    logic [DW-1:0]           word;
    logic                    last;
    logic                    push_req;
    logic                    push_ok;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DW-1:0]           fifo_head;
    logic                    unused_word_hi;

    assign last      = (phase_q == PH_W'(D - 1));
    assign sum       = acc_q + ACC_W'(bus.in_data);
    assign word_wide = round_shift_sat(32'(sum), LOG2_DECIM, DW);
    assign word      = word_wide[DW-1:0];
    // Clamping guarantees the upper bits are only sign copies of word.
    assign unused_word_hi = ^word_wide[31:DW];

    assign pop     = bus.out_valid && bus.out_ready;
    assign push_ok = push_req && (!fifo_full || pop);

    always_comb begin
        phase_d      = phase_q;
        acc_d        = acc_q;
        push_req     = 1'b0;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (bus.in_valid) begin
            if (last) begin
                push_req = 1'b1;
                phase_d  = '0;
                acc_d    = '0;
            end else begin
                phase_d  = phase_q + PH_W'(1);
                acc_d    = sum;
            end
        end
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= '0;
            acc_q        <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            phase_q      <= phase_d;
            acc_q        <= acc_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_ok),
        .pop     (pop),
        .wr_data (word),
        .rd_data (fifo_head),
        .level   (bus.level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = fifo_head;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_count_q;

endmodule
